// File: rtl/img_load_ctrl.sv
// Image load controller: checks the frame geometry, then scatters a raster pixel
// stream over four byte banks by (x,y) parity and reports row progress to a scaler.
module img_load_ctrl #(
    parameter int ABW  = 13,
    parameter int DIMW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            abort,
    input  logic [31:0]     img0x,
    input  logic [31:0]     img0y,
    input  logic            s_valid,
    input  logic [7:0]      s_data,
    output logic            s_ready,
    input  logic            finish,
    output logic            wea1,
    output logic            wea2,
    output logic            wea3,
    output logic            wea4,
    output logic            ena1,
    output logic            ena2,
    output logic            ena3,
    output logic            ena4,
    output logic [ABW-1:0]  AA1,
    output logic [ABW-1:0]  AA2,
    output logic [ABW-1:0]  AA3,
    output logic [ABW-1:0]  AA4,
    output logic [7:0]      DA1,
    output logic [7:0]      DA2,
    output logic [7:0]      DA3,
    output logic [7:0]      DA4,
    output logic [31:0]     row_signal,
    output logic            img_start,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_FIN,
        DONE
    } state_t;

    localparam logic [2*DIMW:0] BANK_DEPTH = {{(2*DIMW){1'b0}}, 1'b1} << ABW;

    state_t state, state_nx;

    logic [DIMW-1:0] w_q, h_q, half_w_q;
    logic [DIMW-1:0] x_q, y_q;
    logic [ABW-1:0]  row_base_q;
    logic            pix_done_q;
    logic            row_end_q;
    logic            fin_pend_q;
    logic [3:0]      we_q;
    logic [ABW-1:0]  aa_q [4];
    logic [7:0]      da_q [4];

    logic [DIMW-1:0]   cfg_w, cfg_h, cfg_half_w, cfg_half_h;
    logic [DIMW:0]     cfg_w_p1, cfg_h_p1;
    logic [2*DIMW-1:0] cfg_area;
    logic              cfg_ok;

    logic            take;
    logic            last_col, last_row;
    logic [1:0]      wr_bank;
    logic [ABW-1:0]  wr_addr;
    logic [31:0]     start_rows;

    assign cfg_w = img0x[DIMW-1:0];
    assign cfg_h = img0y[DIMW-1:0];

    generate
        if (DIMW < 32) begin : g_unused
            logic unused_dim_bits;
            assign unused_dim_bits = ^{img0x[31:DIMW], img0y[31:DIMW]};
        end
    endgenerate

    // The single multiply in the block: ceil(W/2)*ceil(H/2) must fit one bank.
    always_comb begin
        cfg_w_p1   = {1'b0, cfg_w} + {{DIMW{1'b0}}, 1'b1};
        cfg_h_p1   = {1'b0, cfg_h} + {{DIMW{1'b0}}, 1'b1};
        cfg_half_w = cfg_w_p1[DIMW:1];
        cfg_half_h = cfg_h_p1[DIMW:1];
        cfg_area   = {{DIMW{1'b0}}, cfg_half_w} * {{DIMW{1'b0}}, cfg_half_h};
        cfg_ok     = (cfg_w != '0) && (cfg_h != '0) && ({1'b0, cfg_area} <= BANK_DEPTH);
    end

    assign take       = s_valid && s_ready && !abort;
    assign last_col   = (x_q == w_q - DIMW'(1));
    assign last_row   = (y_q == h_q - DIMW'(1));
    assign wr_bank    = {y_q[0], x_q[0]};
    assign wr_addr    = row_base_q + ABW'(x_q >> 1);
    assign start_rows = (h_q >= DIMW'(2)) ? 32'd2 : 32'(h_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            // NOTE: every clocked register uses <= so all flops sample the same pre-edge values.
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
        state_nx = state;
        s_ready  = 1'b0;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE:     if (frame_start && cfg_ok) state_nx = LOAD;
            LOAD: begin
                s_ready = !pix_done_q;
                if (pix_done_q && row_end_q) state_nx = WAIT_FIN;
            end
            WAIT_FIN: if (finish || fin_pend_q) state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q        <= '0;
            h_q        <= '0;
            half_w_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            pix_done_q <= 1'b0;
            row_end_q  <= 1'b0;
            fin_pend_q <= 1'b0;
            we_q       <= '0;
            row_signal <= '0;
            img_start  <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                aa_q[i] <= '0;
                da_q[i] <= '0;
            end
        end else begin
            we_q      <= '0;
            img_start <= 1'b0;
            row_end_q <= 1'b0;
            if (abort) begin
                row_signal <= '0;
                fin_pend_q <= 1'b0;
                pix_done_q <= 1'b0;
            end else begin
                if (state == IDLE && frame_start) begin
                    w_q      <= cfg_w;
                    h_q      <= cfg_h;
                    half_w_q <= cfg_half_w;
                    err      <= !cfg_ok;
                    if (cfg_ok) begin
                        x_q        <= '0;
                        y_q        <= '0;
                        row_base_q <= '0;
                        row_signal <= '0;
                        pix_done_q <= 1'b0;
                        fin_pend_q <= 1'b0;
                    end
                end

                if (state == LOAD && finish) begin
                    fin_pend_q <= 1'b1;
                end else if (state == WAIT_FIN) begin
                    fin_pend_q <= 1'b0;
                end

                // Row base advances by ceil(W/2) after each odd row: banks hold row pairs.
                if (take) begin
                    we_q[wr_bank] <= 1'b1;
                    aa_q[wr_bank] <= wr_addr;
                    da_q[wr_bank] <= s_data;
                    if (last_col) begin
                        x_q       <= '0;
                        y_q       <= y_q + DIMW'(1);
                        row_end_q <= 1'b1;
                        if (y_q[0]) row_base_q <= row_base_q + ABW'(half_w_q);
                        if (last_row) pix_done_q <= 1'b1;
                    end else begin
                        x_q <= x_q + DIMW'(1);
                    end
                end

                if (row_end_q) begin
                    row_signal <= row_signal + 32'd1;
                    img_start  <= (row_signal + 32'd1 == start_rows);
                end
            end
        end
    end

    assign wea1 = we_q[0];
    assign wea2 = we_q[1];
    assign wea3 = we_q[2];
    assign wea4 = we_q[3];
    assign ena1 = we_q[0];
    assign ena2 = we_q[1];
    assign ena3 = we_q[2];
    assign ena4 = we_q[3];
    assign AA1  = aa_q[0];
    assign AA2  = aa_q[1];
    assign AA3  = aa_q[2];
    assign AA4  = aa_q[3];
    assign DA1  = da_q[0];
    assign DA2  = da_q[1];
    assign DA3  = da_q[2];
    assign DA4  = da_q[3];

endmodule

// File: tb/tb_img_load_ctrl.sv
// Directed bench for img_load_ctrl: a raster model predicts every bank write,
// row_signal/img_start per cycle, and the handshake around frame completion.
module tb_img_load_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start, abort, s_valid, finish;
    logic [31:0] img0x, img0y;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        wea1, wea2, wea3, wea4, ena1, ena2, ena3, ena4;
    logic [12:0] AA1, AA2, AA3, AA4;
    logic [7:0]  DA1, DA2, DA3, DA4;
    logic [31:0] row_signal;
    logic        img_start, busy, done, err;

    img_load_ctrl dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .abort(abort),
        .img0x(img0x), .img0y(img0y), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .finish(finish),
        .wea1(wea1), .wea2(wea2), .wea3(wea3), .wea4(wea4),
        .ena1(ena1), .ena2(ena2), .ena3(ena3), .ena4(ena4),
        .AA1(AA1), .AA2(AA2), .AA3(AA3), .AA4(AA4),
        .DA1(DA1), .DA2(DA2), .DA3(DA3), .DA4(DA4),
        .row_signal(row_signal), .img_start(img_start),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bank;
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  vec_cnt = 0;
    int  miscmp_cnt = 0;
    int  mw, mh, mx, my;
    int  exp_rows, start_target, start_rows_seen;
    bit  row_pend, exp_start;
    int  bank_cnt [4];
    int  cap_bank [64];
    int  cap_addr [64];
    int  cap_n;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [12:0] aa_of(input int b);
        case (b)
            1: return AA1;
            2: return AA2;
            3: return AA3;
            default: return AA4;
        endcase
    endfunction

    function automatic logic [7:0] da_of(input int b);
        case (b)
            1: return DA1;
            2: return DA2;
            3: return DA3;
            default: return DA4;
        endcase
    endfunction

    // Write monitor: each strobe must match the oldest predicted write, one cycle after its handshake.
    always @(negedge clk) begin
        int  nh, b;
        wr_t e;
        nh = int'(wea1) + int'(wea2) + int'(wea3) + int'(wea4);
        if (nh != 0 || {ena4, ena3, ena2, ena1} != 4'b0) begin
            check("wr_onehot", nh, 1);
            check("wr_ena", {ena4, ena3, ena2, ena1}, {wea4, wea3, wea2, wea1});
            b = wea1 ? 1 : wea2 ? 2 : wea3 ? 3 : 4;
            bank_cnt[b-1]++;
            if (cap_n < 64) begin
                cap_bank[cap_n] = b;
                cap_addr[cap_n] = int'(aa_of(b));
            end
            cap_n++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", b, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_bank", b, e.bank);
                check("wr_addr", aa_of(b), e.addr);
                check("wr_data", da_of(b), e.data);
            end
        end else if (exp_q.size() != 0) begin
            check("wr_missing", 0, exp_q.size());
            exp_q.delete();
        end
    end

    task automatic tick();
        bit  hs, ab, row_end;
        wr_t e;
        hs      = rst && s_valid && s_ready && !abort;
        ab      = rst && abort;
        row_end = hs && (mx == mw - 1);
        e.bank  = 1 + 2 * (my % 2) + (mx % 2);
        e.addr  = ((my / 2) * ((mw + 1) / 2) + mx / 2) % 8192;
        e.data  = int'(s_data);
        @(posedge clk);
        #1;
        if (hs) begin
            exp_q.push_back(e);
            if (mx == mw - 1) begin
                mx = 0;
                my++;
            end else begin
                mx++;
            end
        end
        if (ab) begin
            exp_rows  = 0;
            row_pend  = 1'b0;
            exp_start = 1'b0;
        end else begin
            exp_start = row_pend && (exp_rows + 1 == start_target);
            if (row_pend) exp_rows++;
            row_pend = row_end;
        end
        if (rst) begin
            check("row_signal", row_signal, exp_rows);
            check("img_start", img_start, exp_start);
        end
        if (img_start) start_rows_seen = int'(row_signal);
    endtask

    task automatic start_frame(input int w, input int h, input bit ok);
        img0x = {16'hA5A5, 16'(w)};
        img0y = {16'h5A5A, 16'(h)};
        if (ok) begin
            mw = w; mh = h; mx = 0; my = 0;
            exp_rows = 0; row_pend = 1'b0;
            start_target = (h >= 2) ? 2 : h;
            start_rows_seen = -1;
            cap_n = 0;
            for (int i = 0; i < 4; i++) bank_cnt[i] = 0;
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("cfg_err", err, !ok);
        check("cfg_busy", busy, ok);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", s_ready, 0);
    endtask

    task automatic feed(input bit gaps, input int fin_cyc, input int abort_pix,
                        input int stop_pix, input int fs_cyc);
        bit ended = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int idx;
            idx = my * mw + mx;
            if (my >= mh || idx == stop_pix) begin
                ended = 1'b1;
                break;
            end
            check("s_ready_load", s_ready, 1);
            s_valid     = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data      = 8'((mx * 7 + my * 29 + 3) & 255);
            finish      = (cyc == fin_cyc);
            frame_start = (cyc == fs_cyc);
            abort       = (idx == abort_pix) && s_valid;
            tick();
            finish      = 1'b0;
            frame_start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                ended = 1'b1;
                break;
            end
        end
        s_valid = 1'b0;
        if (!ended) check("feed_timeout", 0, 1);
    endtask

    task automatic finish_phase(input bit pending);
        check("s_ready_drop", s_ready, 0);
        tick();
        check("rows_final", row_signal, mh);
        if (!pending) begin
            repeat (3) begin
                tick();
                check("wait_busy", busy, 1);
                check("wait_done", done, 0);
            end
            finish = 1'b1;
            tick();
            finish = 1'b0;
        end else begin
            tick();
        end
        check("done_pulse", done, 1);
        tick();
        check("done_clear", done, 0);
        check("idle_busy", busy, 0);
        check("wr_all_seen", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wea"}, {wea4, wea3, wea2, wea1, ena4, ena3, ena2, ena1}, 0);
        check({tag, "_aa"}, {AA4, AA3, AA2, AA1}, 0);
        check({tag, "_da"}, {DA4, DA3, DA2, DA1}, 0);
        check({tag, "_row"}, row_signal, 0);
        check({tag, "_ctl"}, {img_start, done, err, s_ready, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; frame_start = 1'b0; abort = 1'b0; s_valid = 1'b0; finish = 1'b0;
        s_data = 8'h00; img0x = '0; img0y = '0;
        mw = 1; mh = 1; mx = 0; my = 0; exp_rows = 0; row_pend = 1'b0; cap_n = 0;
        start_target = 1; start_rows_seen = -1;
        for (int i = 0; i < 4; i++) bank_cnt[i] = 0;
        #1;
        check_reset_outputs("por");
        tick();
        tick();
        rst = 1'b1;

        // finish in IDLE must not be remembered
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("idle_finish_busy", busy, 0);

        // 4x4, continuous stream
        start_frame(4, 4, 1);
        feed(0, -1, -1, -1, -1);
        finish_phase(0);
        check("t1_p10_bank", cap_bank[1], 2);
        check("t1_p10_addr", cap_addr[1], 0);
        check("t1_p23_bank", cap_bank[14], 3);
        check("t1_p23_addr", cap_addr[14], 3);
        check("t1_start_rows", start_rows_seen, 2);
        for (int i = 0; i < 4; i++) check("t1_bank_cnt", bank_cnt[i], 4);

        // 5x3, odd sizes
        start_frame(5, 3, 1);
        feed(0, -1, -1, -1, -1);
        finish_phase(0);
        check("t2_p42_bank", cap_bank[14], 1);
        check("t2_p42_addr", cap_addr[14], 5);
        check("t2_cnt1", bank_cnt[0], 6);
        check("t2_cnt2", bank_cnt[1], 4);
        check("t2_cnt3", bank_cnt[2], 3);
        check("t2_cnt4", bank_cnt[3], 2);

        // abort together with frame_start in IDLE: abort wins, row_signal cleared
        img0x = 32'd4; img0y = 32'd4;
        frame_start = 1'b1;
        abort = 1'b1;
        tick();
        frame_start = 1'b0;
        abort = 1'b0;
        check("abort_fs_busy", busy, 0);

        // geometry checks
        start_frame(200, 200, 0);
        tick();
        check("rej_busy_hold", busy, 0);
        do_abort();
        check("abort_keeps_err", err, 1);
        start_frame(180, 180, 1);
        do_abort();
        start_frame(0, 4, 0);
        start_frame(256, 129, 0);
        start_frame(256, 128, 1);
        do_abort();

        // gaps, finish pending from mid-LOAD, frame_start ignored while busy
        start_frame(6, 5, 1);
        img0x = 32'd2; img0y = 32'd2;
        feed(1, 10, -1, -1, 5);
        check("t4_err", err, 0);
        finish_phase(1);
        check("t4_cnt1", bank_cnt[0], 9);
        check("t4_cnt2", bank_cnt[1], 9);
        check("t4_cnt3", bank_cnt[2], 6);
        check("t4_cnt4", bank_cnt[3], 6);

        // 1x1: img_start at row_signal 1
        start_frame(1, 1, 1);
        feed(0, 0, -1, -1, -1);
        finish_phase(1);
        check("t5_start_rows", start_rows_seen, 1);

        // abort on the handshake of pixel 7, with a pending finish
        start_frame(4, 4, 1);
        feed(0, 2, 7, -1, -1);
        check("t6_row", row_signal, 0);
        tick();
        check("t6_writes", bank_cnt[0] + bank_cnt[1] + bank_cnt[2] + bank_cnt[3], 7);
        start_frame(2, 2, 1);
        feed(0, -1, -1, -1, -1);
        finish_phase(0);

        // asynchronous reset mid-LOAD
        start_frame(4, 4, 1);
        feed(0, -1, -1, 6, -1);
        check("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("async");
        exp_rows = 0;
        row_pend = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        start_frame(2, 2, 1);
        feed(0, -1, -1, -1, -1);
        finish_phase(0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
